// File: rtl/light_phase_scheduler.sv
// Crossroads light phase scheduler: NS/EW phase sequencing, pedestrian and emergency arbitration, adjustable durations.
// Latency: all outputs follow their inputs by 1 clk; time advances only on tick.
module light_phase_scheduler #(
    parameter int CNT_W   = 8,
    parameter int DEF_FWD = 15,
    parameter int DEF_RGT = 10,
    parameter int DEF_LFT = 10,
    parameter int DEF_OFF = 3,
    parameter int PED_T   = 8,
    parameter int MIN_T   = 1,
    parameter int MAX_T   = 99
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             enable,
    input  logic [1:0]       ped_req,
    input  logic             emg_req,
    input  logic             cfg_en,
    input  logic [1:0]       cfg_sel,
    input  logic             cfg_inc,
    input  logic             cfg_dec,
    output logic [1:0]       phase_ns,
    output logic [1:0]       phase_ew,
    output logic [CNT_W-1:0] remain,
    output logic [1:0]       walk,
    output logic [1:0]       ped_pending,
    output logic             emg_active
);

    localparam logic [2:0] S_ALLRED  = 3'd0;
    localparam logic [2:0] S_FWD     = 3'd1;
    localparam logic [2:0] S_RGT     = 3'd2;
    localparam logic [2:0] S_LFT     = 3'd3;
    localparam logic [2:0] S_WALK    = 3'd4;
    localparam logic [2:0] S_CLEAR_E = 3'd5;
    localparam logic [2:0] S_EMG     = 3'd6;

    localparam logic [1:0] PH_OFF   = 2'b00;
    localparam logic [1:0] PH_LEFT  = 2'b01;
    localparam logic [1:0] PH_FWD   = 2'b10;
    localparam logic [1:0] PH_RIGHT = 2'b11;

    localparam logic [CNT_W-1:0] DUR_PED = CNT_W'(PED_T);
    localparam logic [CNT_W-1:0] DUR_MIN = CNT_W'(MIN_T);
    localparam logic [CNT_W-1:0] DUR_MAX = CNT_W'(MAX_T);

    logic [2:0]       state;
    logic [CNT_W-1:0] dur_off, dur_lft, dur_fwd, dur_rgt;
    logic [CNT_W-1:0] dur_cur, dur_nxt;
    logic [1:0]       ped_hist, ped_rise;
    logic             inc_hist, dec_hist, inc_rise, dec_rise;
    logic             expire, emg_enter, walk_entry;

    always_comb begin
        ped_rise   = ped_req & ~ped_hist;
        inc_rise   = cfg_inc & ~inc_hist;
        dec_rise   = cfg_dec & ~dec_hist;
        expire     = tick && (remain <= CNT_W'(1));
        emg_enter  = emg_req && (state != S_CLEAR_E) && (state != S_EMG);
        walk_entry = enable && !emg_req && (state == S_LFT) && expire && (ped_pending != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_ALLRED;
            remain <= '0;
            walk   <= 2'b00;
        end else if (!enable) begin
            state  <= S_ALLRED;
            remain <= '0;
            walk   <= 2'b00;
        end else if (emg_enter) begin
            state  <= S_CLEAR_E;
            remain <= dur_off;
            walk   <= 2'b00;
        end else if (state == S_EMG) begin
            // Preemption holds with no countdown until the request drops.
            if (!emg_req) begin
                state  <= S_ALLRED;
                remain <= dur_off;
            end
        end else if (expire) begin
            case (state)
                S_ALLRED: begin state <= S_FWD; remain <= dur_fwd; end
                S_FWD:    begin state <= S_RGT; remain <= dur_rgt; end
                S_RGT:    begin state <= S_LFT; remain <= dur_lft; end
                S_LFT: begin
                    if (ped_pending != 2'b00) begin
                        state  <= S_WALK;
                        remain <= DUR_PED;
                        walk   <= ped_pending;
                    end else begin
                        state  <= S_ALLRED;
                        remain <= dur_off;
                    end
                end
                S_WALK: begin
                    state  <= S_ALLRED;
                    remain <= dur_off;
                    walk   <= 2'b00;
                end
                S_CLEAR_E: begin state <= S_EMG; remain <= '0; end
                default:   begin state <= S_ALLRED; remain <= '0; end
            endcase
        end else if (tick) begin
            remain <= remain - CNT_W'(1);
        end
    end

    // A rise landing in the same cycle as WALK entry survives the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ped_pending <= 2'b00;
            ped_hist    <= 2'b00;
            inc_hist    <= 1'b0;
            dec_hist    <= 1'b0;
        end else begin
            ped_pending <= (walk_entry ? 2'b00 : ped_pending) | ped_rise;
            ped_hist    <= ped_req;
            inc_hist    <= cfg_inc;
            dec_hist    <= cfg_dec;
        end
    end

    always_comb begin
        case (cfg_sel)
            2'b00:   dur_cur = dur_off;
            2'b01:   dur_cur = dur_lft;
            2'b10:   dur_cur = dur_fwd;
            default: dur_cur = dur_rgt;
        endcase
        dur_nxt = dur_cur;
        if (inc_rise && !dec_rise && dur_cur < DUR_MAX)
            dur_nxt = dur_cur + CNT_W'(1);
        else if (dec_rise && !inc_rise && dur_cur > DUR_MIN)
            dur_nxt = dur_cur - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dur_off <= CNT_W'(DEF_OFF);
            dur_lft <= CNT_W'(DEF_LFT);
            dur_fwd <= CNT_W'(DEF_FWD);
            dur_rgt <= CNT_W'(DEF_RGT);
        end else if (cfg_en) begin
            case (cfg_sel)
                2'b00:   dur_off <= dur_nxt;
                2'b01:   dur_lft <= dur_nxt;
                2'b10:   dur_fwd <= dur_nxt;
                default: dur_rgt <= dur_nxt;
            endcase
        end
    end

    always_comb begin
        phase_ns   = PH_OFF;
        phase_ew   = PH_OFF;
        emg_active = 1'b0;
        case (state)
            S_FWD:     phase_ns = PH_FWD;
            S_RGT:     begin phase_ns = PH_RIGHT; phase_ew = PH_LEFT;  end
            S_LFT:     begin phase_ns = PH_LEFT;  phase_ew = PH_RIGHT; end
            S_CLEAR_E: emg_active = 1'b1;
            S_EMG:     begin phase_ns = PH_FWD; emg_active = 1'b1; end
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_light_phase_scheduler.sv
// Bench for light_phase_scheduler: per-cycle reference scoreboard plus directed checks of the documented scenarios.
module tb_light_phase_scheduler;

    logic       clk = 1'b0;
    logic       reset, tick, enable, emg_req, cfg_en, cfg_inc, cfg_dec;
    logic [1:0] ped_req, cfg_sel;
    logic [1:0] phase_ns, phase_ew, walk, ped_pending;
    logic [7:0] remain;
    logic       emg_active;

    always #5 clk = ~clk;

    light_phase_scheduler dut (
        .clk(clk), .reset(reset), .tick(tick), .enable(enable), .ped_req(ped_req),
        .emg_req(emg_req), .cfg_en(cfg_en), .cfg_sel(cfg_sel), .cfg_inc(cfg_inc),
        .cfg_dec(cfg_dec), .phase_ns(phase_ns), .phase_ew(phase_ew), .remain(remain),
        .walk(walk), .ped_pending(ped_pending), .emg_active(emg_active)
    );

    typedef struct packed {
        logic [1:0] ns;
        logic [1:0] ew;
        logic [7:0] rem;
        logic [1:0] wk;
        logic [1:0] pend;
        logic       emg;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tick_per = 0;
    int   tcnt = 0;
    int   n_ticks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Reference model, states: 0 ALLRED 1 FWD 2 RGT 3 LFT 4 WALK 5 CLEAR_E 6 EMG
    int         m_st, m_rem;
    int         m_dur[4];   // indexed by cfg_sel: OFF, LEFT, FORWARD, RIGHT
    logic [1:0] m_walk, m_pend, m_ped_h;
    logic       m_inc_h, m_dec_h;

    function automatic obs_t model_out();
        obs_t o;
        o = '0;
        case (m_st)
            1: o.ns = 2'b10;
            2: begin o.ns = 2'b11; o.ew = 2'b01; end
            3: begin o.ns = 2'b01; o.ew = 2'b11; end
            5: o.emg = 1'b1;
            6: begin o.ns = 2'b10; o.emg = 1'b1; end
            default: ;
        endcase
        o.rem  = 8'(m_rem);
        o.wk   = m_walk;
        o.pend = m_pend;
        return o;
    endfunction

    task automatic model_step();
        logic [1:0] rise;
        logic       ir, dr;
        int         d_old[4];
        if (reset) begin
            m_st = 0; m_rem = 0; m_walk = 0; m_pend = 0;
            m_ped_h = 0; m_inc_h = 0; m_dec_h = 0;
            m_dur = '{3, 10, 15, 10};
            return;
        end
        rise  = ped_req & ~m_ped_h;
        ir    = cfg_inc & ~m_inc_h;
        dr    = cfg_dec & ~m_dec_h;
        d_old = m_dur;
        if (!enable) begin
            m_st = 0; m_rem = 0; m_walk = 0;
        end else if (emg_req && m_st != 5 && m_st != 6) begin
            m_st = 5; m_rem = d_old[0]; m_walk = 0;
        end else if (m_st == 6) begin
            if (!emg_req) begin m_st = 0; m_rem = d_old[0]; end
        end else if (tick && m_rem <= 1) begin
            case (m_st)
                0: begin m_st = 1; m_rem = d_old[2]; end
                1: begin m_st = 2; m_rem = d_old[3]; end
                2: begin m_st = 3; m_rem = d_old[1]; end
                3: if (m_pend != 0) begin
                       m_st = 4; m_rem = 8; m_walk = m_pend; m_pend = 0;
                   end else begin
                       m_st = 0; m_rem = d_old[0];
                   end
                4: begin m_st = 0; m_rem = d_old[0]; m_walk = 0; end
                default: begin m_st = 6; m_rem = 0; end
            endcase
        end else if (tick) begin
            m_rem = m_rem - 1;
        end
        m_pend = m_pend | rise;
        if (cfg_en && ir != dr) begin
            if (ir && m_dur[cfg_sel] < 99) m_dur[cfg_sel] = m_dur[cfg_sel] + 1;
            if (dr && m_dur[cfg_sel] > 1)  m_dur[cfg_sel] = m_dur[cfg_sel] - 1;
        end
        m_ped_h = ped_req;
        m_inc_h = cfg_inc;
        m_dec_h = cfg_dec;
    endtask

    task automatic cyc();
        obs_t a, e;
        model_step();
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        a = {phase_ns, phase_ew, remain, walk, ped_pending, emg_active};
        e = exp_q.pop_front();
        check("sb_phase_ns", a.ns, e.ns);
        check("sb_phase_ew", a.ew, e.ew);
        check("sb_remain", a.rem, e.rem);
        check("sb_walk", a.wk, e.wk);
        check("sb_ped_pending", a.pend, e.pend);
        check("sb_emg_active", a.emg, e.emg);
    endtask

    task automatic step();
        tick = (tick_per != 0) && (tcnt % tick_per == tick_per - 1);
        tcnt++;
        if (tick) n_ticks++;
        cyc();
    endtask

    task automatic wait_state(input string tag, input logic [1:0] ns, input logic [1:0] ew,
                              input logic [1:0] wk, input logic em, input int limit);
        int   k;
        logic hit;
        k = 0;
        hit = (phase_ns == ns && phase_ew == ew && walk == wk && emg_active == em);
        while (!hit && k < limit) begin
            step();
            k++;
            hit = (phase_ns == ns && phase_ew == ew && walk == wk && emg_active == em);
        end
        check({tag, "_reached"}, hit, 1);
    endtask

    int t0, k;

    initial begin
        // T1: reset wins over every input held high
        reset = 1; tick = 1; enable = 1; ped_req = 2'b11; emg_req = 1;
        cfg_en = 1; cfg_sel = 2'b10; cfg_inc = 1; cfg_dec = 1;
        cyc(); cyc();
        check("t1_phase_ns", phase_ns, 0);
        check("t1_phase_ew", phase_ew, 0);
        check("t1_remain", remain, 0);
        check("t1_walk", walk, 0);
        check("t1_emg_active", emg_active, 0);

        reset = 0; tick = 0; ped_req = 0; emg_req = 0; cfg_en = 0; cfg_inc = 0; cfg_dec = 0;
        enable = 1; tick_per = 4;

        // T2: normal cycle and default durations
        wait_state("t2_fwd", 2'b10, 2'b00, 2'b00, 0, 40);
        check("t2_fwd_dur", remain, 15);
        t0 = n_ticks;
        wait_state("t2_rgt", 2'b11, 2'b01, 2'b00, 0, 200);
        check("t2_rgt_dur", remain, 10);
        wait_state("t2_lft", 2'b01, 2'b11, 2'b00, 0, 200);
        check("t2_lft_dur", remain, 10);
        wait_state("t2_allred", 2'b00, 2'b00, 2'b00, 0, 200);
        check("t2_off_dur", remain, 3);
        wait_state("t2_fwd2", 2'b10, 2'b00, 2'b00, 0, 200);
        check("t2_period", n_ticks - t0, 38);

        // T3: EW pedestrian request served after LFT
        ped_req = 2'b10; step(); ped_req = 2'b00;
        check("t3_pending", ped_pending, 2'b10);
        wait_state("t3_walk", 2'b00, 2'b00, 2'b10, 0, 300);
        check("t3_walk_dur", remain, 8);
        check("t3_pending_clr", ped_pending, 0);
        t0 = n_ticks;
        wait_state("t3_allred", 2'b00, 2'b00, 2'b00, 0, 200);
        check("t3_walk_ticks", n_ticks - t0, 8);

        // T4: emergency preemption at FWD remain 7
        wait_state("t4_fwd", 2'b10, 2'b00, 2'b00, 0, 200);
        k = 0;
        while (remain != 7 && k < 100) begin step(); k++; end
        check("t4_remain7", remain, 7);
        emg_req = 1; tick = 0; cyc();
        check("t4_clear_emg", emg_active, 1);
        check("t4_clear_ns", phase_ns, 0);
        check("t4_clear_rem", remain, 3);
        wait_state("t4_emg", 2'b10, 2'b00, 2'b00, 1, 40);
        check("t4_emg_rem", remain, 0);
        for (int i = 0; i < 20; i++) step();
        check("t4_emg_hold", {phase_ns, emg_active}, 3'b101);
        emg_req = 0; step();
        check("t4_exit_emg", emg_active, 0);
        check("t4_exit_ns", phase_ns, 0);
        check("t4_exit_rem", remain, 3);
        // One-cycle request still runs CLEAR_E -> EMG -> ALLRED
        emg_req = 1; step(); emg_req = 0;
        check("t4_pulse_clear", emg_active, 1);
        wait_state("t4_pulse_emg", 2'b10, 2'b00, 2'b00, 1, 40);
        step();
        check("t4_pulse_back", {phase_ns, emg_active, remain}, {2'b00, 1'b0, 8'd3});

        // T5: duration editing with ticks frozen
        tick_per = 0;
        cfg_en = 1; cfg_sel = 2'b10;
        for (int i = 0; i < 90; i++) begin cfg_inc = 1; step(); cfg_inc = 0; step(); end
        cfg_sel = 2'b00;
        for (int i = 0; i < 5; i++) begin cfg_dec = 1; step(); cfg_dec = 0; step(); end
        cfg_sel = 2'b11;
        cfg_inc = 1; cfg_dec = 1; step(); cfg_inc = 0; cfg_dec = 0; step();
        cfg_en = 0; cfg_sel = 2'b01;
        for (int i = 0; i < 4; i++) begin cfg_inc = 1; step(); cfg_inc = 0; step(); end
        tick_per = 1;
        wait_state("t5_fwd", 2'b10, 2'b00, 2'b00, 0, 20);
        check("t5_fwd_sat", remain, 99);
        wait_state("t5_rgt", 2'b11, 2'b01, 2'b00, 0, 200);
        check("t5_rgt_both", remain, 10);
        wait_state("t5_lft", 2'b01, 2'b11, 2'b00, 0, 50);
        check("t5_lft_locked", remain, 10);
        wait_state("t5_allred", 2'b00, 2'b00, 2'b00, 0, 50);
        check("t5_off_sat", remain, 1);

        // T6: disable mid-RGT, pedestrian request latched while disabled
        tick_per = 2;
        wait_state("t6_rgt", 2'b11, 2'b01, 2'b00, 0, 400);
        for (int i = 0; i < 3; i++) step();
        enable = 0; step();
        check("t6_dis_phase", {phase_ns, phase_ew}, 4'b0000);
        check("t6_dis_remain", remain, 0);
        check("t6_dis_walk", walk, 0);
        ped_req = 2'b01; step(); ped_req = 2'b00;
        for (int i = 0; i < 6; i++) step();
        check("t6_dis_pending", ped_pending, 2'b01);
        check("t6_dis_hold", {phase_ns, remain}, 10'd0);
        enable = 1;
        wait_state("t6_fwd", 2'b10, 2'b00, 2'b00, 0, 4);
        check("t6_fwd_dur", remain, 99);
        wait_state("t6_walk", 2'b00, 2'b00, 2'b01, 0, 600);
        check("t6_walk_rem", remain, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
